// File: rtl/wb_status_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wb_status_slave
//  Description : Wishbone classic single-cycle status/control slave.
//                Provides VERSION, SCRATCH, CTRL, sticky FLAGS with mask
//                and registered interrupt, plus a free-running cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_status_slave #(
  parameter logic [23:0] BASE_ADR = 24'h000000,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [7:0]  event_i,
  output logic [31:0] ctrl_o,
  output logic        ctrl_strobe_o,
  output logic        irq_o
);

  // Register word offsets (byte address bits [7:2])
  localparam logic [5:0] c_off_version = 6'h00;
  localparam logic [5:0] c_off_scratch = 6'h01;
  localparam logic [5:0] c_off_ctrl    = 6'h02;
  localparam logic [5:0] c_off_flags   = 6'h03;
  localparam logic [5:0] c_off_mask    = 6'h04;
  localparam logic [5:0] c_off_cycles  = 6'h05;

  // Architectural state and next-state values
  logic        ack_q,     ack_d;
  logic [31:0] dat_q,     dat_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q,    ctrl_d;
  logic        strobe_q,  strobe_d;
  logic [7:0]  flags_q,   flags_d;
  logic [7:0]  mask_q,    mask_d;
  logic [31:0] cycles_q,  cycles_d;
  logic        irq_q,     irq_d;

  // Bus decode
  logic        w_sel;
  logic        w_request;
  logic        w_write;
  logic [5:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused_adr;

  // The ack term blocks a second request while the current one is being
  // acknowledged, so a held strobe is served on every other cycle.
  assign w_sel     = (wb_adr_i[31:8] == BASE_ADR);
  assign w_request = wb_cyc_i & wb_stb_i & w_sel & ~ack_q;
  assign w_write   = w_request & wb_we_i;
  assign w_off     = wb_adr_i[7:2];

  // Byte-lane bits carry no meaning here; all accesses are full words.
  assign w_unused_adr = &{1'b0, wb_adr_i[1:0]};

  // Read multiplexer, evaluated on the request-sample edge
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      c_off_version: w_rdata = VERSION;
      c_off_scratch: w_rdata = scratch_q;
      c_off_ctrl:    w_rdata = ctrl_q;
      c_off_flags:   w_rdata = {24'h0, flags_q};
      c_off_mask:    w_rdata = {24'h0, mask_q};
      c_off_cycles:  w_rdata = cycles_q;
      default:       w_rdata = 32'h0;
    endcase
  end

  // Next-state logic for bus handshake, register writes, flags and counter
  always_comb begin
    ack_d     = w_request;
    dat_d     = w_request ? w_rdata : 32'h0;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    flags_d   = flags_q;
    strobe_d  = 1'b0;

    if (w_write) begin
      case (w_off)
        c_off_scratch: scratch_d = wb_dat_i;
        c_off_ctrl: begin
          ctrl_d   = wb_dat_i;
          strobe_d = 1'b1;
        end
        c_off_flags:   flags_d = flags_q & ~wb_dat_i[7:0];
        c_off_mask:    mask_d  = wb_dat_i[7:0];
        default:       ;
      endcase
    end

    // Applied after the clear so a coincident event wins over write-1-to-clear
    flags_d  = flags_d | event_i;

    cycles_d = cycles_q + 32'd1;

    // Interrupt follows the flag/mask state with one cycle of latency
    irq_d    = |(flags_q & mask_q);
  end

  // State registers; active-low synchronous reset aborts any in-flight access
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      scratch_q <= 32'h0;
      ctrl_q    <= 32'h0;
      strobe_q  <= 1'b0;
      flags_q   <= 8'h0;
      mask_q    <= 8'h0;
      cycles_q  <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      strobe_q  <= strobe_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      cycles_q  <= cycles_d;
      irq_q     <= irq_d;
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign ctrl_o        = ctrl_q;
  assign ctrl_strobe_o = strobe_q;
  assign irq_o         = irq_q;

endmodule
`default_nettype wire
